// File: rtl/ro_puf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ro_puf_pkg
//  Description : Shared types and constants for the RO-PUF challenge
//                sequencer: FSM state encoding, synchronizer depth and the
//                number of pipeline-flush cycles after each window.
//  Revision    : 1.0 - initial release
// ============================================================================
package ro_puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Flops between the asynchronous RO output and the edge detector.
    localparam int C_SYNC_DEPTH   = 2;

    // Cycles after the window with counting still enabled, long enough to
    // push the last edge through the synchronizer and the previous-value flop.
    localparam int C_DRAIN_CYCLES = 2;

endpackage : ro_puf_pkg
`default_nettype wire

// File: rtl/ro_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ro_edge_counter
//  Description : Synchronizes one asynchronous divided-RO output, detects
//                rising edges and counts them in a saturating counter.
//  Ports       : clk, rst  - system clock, synchronous active-high reset
//                din       - asynchronous RO divider output
//                clr       - clear the count (priority over en)
//                en        - count enable
//                cnt       - current edge count (saturates at all-ones)
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int SYNC_DEPTH = C_SYNC_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  r_prev;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_rise;

    assign w_rise = r_sync[SYNC_DEPTH-1] & ~r_prev;
    assign cnt    = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], din};
            r_prev <= r_sync[SYNC_DEPTH-1];
            if (clr) begin
                r_cnt <= '0;
            end else if (en && w_rise && (r_cnt != C_CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule : ro_edge_counter
`default_nettype wire

// File: rtl/ro_puf_challenge_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ro_puf_challenge_sequencer
//  Description : Walks RESP_BITS ring-oscillator pairs per challenge. Each
//                pair is enabled, allowed to settle, edge-counted over a fixed
//                window and compared; the resulting bits are returned on a
//                valid/ready handshake together with a tie mask.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                chal_valid/chal_ready   - challenge handshake (ready in IDLE)
//                chal_a, chal_b          - base indices of oscillators A and B
//                chal_err                - 1-cycle pulse, chal_a == chal_b
//                ro_en                   - pair enable to the RO array
//                ro_div                  - divided RO outputs (asynchronous)
//                resp_valid/resp_ready   - response handshake
//                resp, tie_mask          - A>B and A==B bits per pair
//                busy                    - not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module ro_puf_challenge_sequencer
    import ro_puf_pkg::*;
#(
    parameter  int NUM_RO    = 8,
    parameter  int RESP_BITS = 8,
    parameter  int WINDOW    = 1024,
    parameter  int SETTLE    = 4,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = $clog2(NUM_RO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chal_valid,
    output logic                 chal_ready,
    input  logic [IDX_W-1:0]     chal_a,
    input  logic [IDX_W-1:0]     chal_b,
    output logic                 chal_err,
    output logic [NUM_RO-1:0]    ro_en,
    input  logic [NUM_RO-1:0]    ro_div,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp,
    output logic [RESP_BITS-1:0] tie_mask,
    output logic                 busy
);

    localparam int               C_TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int               C_TMR_W   = $clog2(C_TMR_MAX + 1);
    localparam logic [IDX_W-1:0] C_K_LAST  = IDX_W'(RESP_BITS - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [C_TMR_W-1:0]     r_tmr;
    logic [IDX_W-1:0]       r_k;
    logic [IDX_W-1:0]       r_base_a;
    logic [IDX_W-1:0]       r_base_b;
    logic [RESP_BITS-1:0]   r_resp;
    logic [RESP_BITS-1:0]   r_tie;
    logic                   r_chal_err;
    logic [NUM_RO-1:0]      r_ro_en;

    logic [IDX_W-1:0]       w_k_next;
    logic [IDX_W-1:0]       w_base_a_next;
    logic [IDX_W-1:0]       w_base_b_next;
    logic [IDX_W-1:0]       w_idx_a_next;
    logic [IDX_W-1:0]       w_idx_b_next;
    logic [NUM_RO-1:0]      w_ro_en_next;
    logic                   w_accept;
    logic                   w_reject;

    logic [IDX_W-1:0]       w_idx_a;
    logic [IDX_W-1:0]       w_idx_b;
    logic [CNT_W-1:0]       w_cnt_a;
    logic [CNT_W-1:0]       w_cnt_b;
    logic                   w_cnt_clr;
    logic                   w_cnt_en;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, next pair index and next enable pattern
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_k_next      = r_k;
        w_base_a_next = r_base_a;
        w_base_b_next = r_base_b;
        w_accept      = 1'b0;
        w_reject      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (chal_valid) begin
                    if (chal_a == chal_b) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept      = 1'b1;
                        w_next        = S_SETTLE;
                        w_base_a_next = chal_a;
                        w_base_b_next = chal_b;
                        w_k_next      = '0;
                    end
                end
            end
            S_SETTLE: begin
                if (r_tmr == C_TMR_W'(SETTLE - 1)) w_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (r_tmr == C_TMR_W'(WINDOW - 1)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_tmr == C_TMR_W'(C_DRAIN_CYCLES - 1)) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                if (r_k == C_K_LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_next   = S_SETTLE;
                    w_k_next = r_k + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (resp_ready) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Natural IDX_W wrap gives the modulo-NUM_RO pair index.
        w_idx_a_next = w_base_a_next + w_k_next;
        w_idx_b_next = w_base_b_next + w_k_next;

        // The enable is registered from the next state so the RO array sees
        // a clean flop output, and reset clears it on the same edge.
        w_ro_en_next = '0;
        if ((w_next == S_SETTLE) || (w_next == S_MEASURE)) begin
            w_ro_en_next = (NUM_RO'(1) << w_idx_a_next) | (NUM_RO'(1) << w_idx_b_next);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr      <= '0;
            r_k        <= '0;
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_resp     <= '0;
            r_tie      <= '0;
            r_chal_err <= 1'b0;
            r_ro_en    <= '0;
        end else begin
            // Each state times itself from zero.
            r_tmr      <= (w_next != r_state) ? '0 : r_tmr + C_TMR_W'(1);
            r_k        <= w_k_next;
            r_base_a   <= w_base_a_next;
            r_base_b   <= w_base_b_next;
            r_chal_err <= w_reject;
            r_ro_en    <= w_ro_en_next;

            if (w_accept) begin
                r_resp <= '0;
                r_tie  <= '0;
            end else if (r_state == S_COMPARE) begin
                for (int i = 0; i < RESP_BITS; i++) begin
                    if (r_k == IDX_W'(i)) begin
                        r_resp[i] <= (w_cnt_a > w_cnt_b);
                        r_tie[i]  <= (w_cnt_a == w_cnt_b);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge counters. The pair index is stable whenever ro_en is set, so the
    // mux ahead of the synchronizers only switches while the ROs are off.
    // ------------------------------------------------------------------
    assign w_idx_a   = r_base_a + r_k;
    assign w_idx_b   = r_base_b + r_k;
    assign w_cnt_clr = (r_state == S_SETTLE);
    assign w_cnt_en  = (r_state == S_MEASURE) || (r_state == S_DRAIN);

    ro_edge_counter #(
        .CNT_W      (CNT_W),
        .SYNC_DEPTH (C_SYNC_DEPTH)
    ) u_cnt_a (
        .clk (clk),
        .rst (rst),
        .din (ro_div[w_idx_a]),
        .clr (w_cnt_clr),
        .en  (w_cnt_en),
        .cnt (w_cnt_a)
    );

    ro_edge_counter #(
        .CNT_W      (CNT_W),
        .SYNC_DEPTH (C_SYNC_DEPTH)
    ) u_cnt_b (
        .clk (clk),
        .rst (rst),
        .din (ro_div[w_idx_b]),
        .clr (w_cnt_clr),
        .en  (w_cnt_en),
        .cnt (w_cnt_b)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign chal_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign chal_err   = r_chal_err;
    assign ro_en      = r_ro_en;
    assign resp       = r_resp;
    assign tie_mask   = r_tie;

endmodule : ro_puf_challenge_sequencer
`default_nettype wire
